// File: rtl/apb_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// apb_sram_ctrl_if : APB3/APB4 bus bundle between an APB master and the
//                    apb_sram_ctrl slave.   Rev 1.0
// ============================================================================
interface apb_sram_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [31:0]          paddr;
  logic [WIDTH-1:0]     pwdata;
  logic [WIDTH/8-1:0]   pstrb;
  logic [WIDTH-1:0]     prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// apb_sram_ctrl : APB slave mapping each transfer onto one single-port SRAM
//                 word access; bad addresses/strobes complete with pslverr.
// Rev 1.0
// ============================================================================
module apb_sram_ctrl #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_sram_ctrl_if.slave       apb,
  output logic                 cs,
  output logic                 we,
  output logic [DEPTH_LOG-1:0] ad,
  output logic [WIDTH-1:0]     din,
  input  logic [WIDTH-1:0]     dout
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_DONE  = 3'd3,
    ERR      = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 cs_q, cs_d;
  logic                 we_q, we_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DEPTH_LOG-1:0] ad_q, ad_d;
  logic [WIDTH-1:0]     din_q, din_d;

  logic setup;
  logic decode_err;

  assign setup      = apb.psel && !apb.penable;
  assign decode_err = (apb.paddr[1:0] != 2'b00)
                   || (apb.paddr[31:DEPTH_LOG+2] != '0)
                   || (apb.pwrite && (apb.pstrb != '1));

  always_comb begin
    state_d = state_q;
    ad_d    = ad_q;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (decode_err) begin
            state_d = ERR;
          end else begin
            ad_d    = apb.paddr[DEPTH_LOG+1:2];
            din_d   = apb.pwdata;
            state_d = apb.pwrite ? WR : RD_ISSUE;
          end
        end
      end
      WR:       state_d = IDLE;
      // A master abandoning the read gets no completion.
      RD_ISSUE: state_d = apb.psel ? RD_DONE : IDLE;
      RD_DONE:  state_d = IDLE;
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    cs_d      = (state_d == WR) || (state_d == RD_ISSUE);
    we_d      = (state_d == WR);
    pready_d  = (state_d == WR) || (state_d == RD_DONE) || (state_d == ERR);
    pslverr_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      ad_q      <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      ad_q      <= ad_d;
      din_q     <= din_d;
    end
  end

  assign cs          = cs_q;
  assign we          = we_q;
  assign ad          = ad_q;
  assign din         = din_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = (state_q == RD_DONE) ? dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// tb_apb_sram_ctrl : directed APB transfers with a response scoreboard and a
//                    behavioural single-port SRAM.   Rev 1.0
// ============================================================================
module tb_apb_sram_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int DL    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_sram_ctrl_if #(.WIDTH(WIDTH)) apb ();

  logic             cs;
  logic             we;
  logic [DL-1:0]    ad;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] mem [DEPTH];

  apb_sram_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .apb  (apb),
    .cs   (cs),
    .we   (we),
    .ad   (ad),
    .din  (din),
    .dout (dout)
  );

  // Single-port SRAM: write on cs&we, registered read on cs&!we.
  always @(posedge clk) begin
    if (cs && we)  mem[ad] <= din;
    if (cs && !we) dout    <= mem[ad];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every completion is matched against the oldest expected response.
  always @(negedge clk) begin : mon
    resp_t r;
    if (!rst && apb.pready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pready", 32'(apb.pready), 32'd0);
      end else begin
        r = sb_q.pop_front();
        check("sb_prdata", apb.prdata, r.rdata);
        check("sb_pslverr", 32'(apb.pslverr), 32'(r.err));
      end
    end
  end

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    int exp_lat;
    exp_lat     = (wr || exp_err) ? 1 : 2;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = data;
    apb.pstrb   = strb;
    sb_q.push_back(resp_t'{exp_rd, exp_err});
    @(posedge clk);
    #1 apb.penable = 1'b1;
    @(negedge clk);
    if (exp_err) begin
      check("err_cs_t1", 32'(cs), 32'd0);
    end else if (wr) begin
      check("wr_cs_t1", 32'(cs), 32'd1);
      check("wr_we_t1", 32'(we), 32'd1);
      check("wr_ad_t1", 32'(ad), 32'(addr[4:2]));
      check("wr_din_t1", din, data);
    end else begin
      check("rd_cs_t1", 32'(cs), 32'd1);
      check("rd_we_t1", 32'(we), 32'd0);
      check("rd_ad_t1", 32'(ad), 32'(addr[4:2]));
    end
    lat = 1;
    while (!apb.pready && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    if (!apb.pready) begin
      check("pready_timeout", 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      check("latency", 32'(lat), 32'(exp_lat));
      if (!wr && !exp_err) check("rd_cs_t2", 32'(cs), 32'd0);
    end
    @(posedge clk);
    #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"},      32'(cs),          32'd0);
    check({tag, "_we"},      32'(we),          32'd0);
    check({tag, "_ad"},      32'(ad),          32'd0);
    check({tag, "_din"},     din,              32'd0);
    check({tag, "_pready"},  32'(apb.pready),  32'd0);
    check({tag, "_pslverr"}, 32'(apb.pslverr), 32'd0);
    check({tag, "_prdata"},  apb.prdata,       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill every word, then read all back.
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, 32'(4 * i), 32'h10 + 32'(i), 4'hF, 32'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 32'(4 * i), 32'd0, 4'h0, 32'h10 + 32'(i), 1'b0);

    // Write followed immediately by read of the same word.
    xfer(1'b1, 32'h1C, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    xfer(1'b0, 32'h1C, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // Decode errors must not disturb the array.
    xfer(1'b0, 32'h20, 32'd0, 4'h0, 32'd0, 1'b1);
    xfer(1'b0, 32'h02, 32'd0, 4'h0, 32'd0, 1'b1);
    xfer(1'b1, 32'h04, 32'hFFFF_FFFF, 4'b0111, 32'd0, 1'b1);
    xfer(1'b0, 32'h04, 32'd0, 4'h0, 32'h11, 1'b0);

    // Access phase with no setup phase.
    apb.psel    = 1'b1;
    apb.penable = 1'b1;
    apb.pwrite  = 1'b1;
    apb.paddr   = 32'h0;
    apb.pwdata  = 32'hBAD0_BAD0;
    apb.pstrb   = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("nosetup_cs", 32'(cs), 32'd0);
      check("nosetup_pready", 32'(apb.pready), 32'd0);
    end
    @(posedge clk);
    #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    @(posedge clk);
    #1;

    // psel dropped while the read is being issued.
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = 32'h04;
    @(posedge clk);
    #1;
    apb.psel    = 1'b0;
    @(negedge clk);
    check("drop_cs_t1", 32'(cs), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("drop_cs", 32'(cs), 32'd0);
      check("drop_pready", 32'(apb.pready), 32'd0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a read.
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = 32'h08;
    @(posedge clk);
    #1 apb.penable = 1'b1;
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    #2;
    rst         = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    @(posedge clk);
    #1;
    xfer(1'b0, 32'h08, 32'd0, 4'h0, 32'h12, 1'b0);

    // Last word then first word, back to back.
    xfer(1'b1, 32'h1C, 32'hA5A5_0007, 4'hF, 32'd0, 1'b0);
    xfer(1'b1, 32'h00, 32'h5A5A_0000, 4'hF, 32'd0, 1'b0);
    xfer(1'b0, 32'h1C, 32'd0, 4'h0, 32'hA5A5_0007, 1'b0);
    xfer(1'b0, 32'h00, 32'd0, 4'h0, 32'h5A5A_0000, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
